// File: rtl/reg_wb_pkg.sv
// Shared definitions for the register-file writeback block.
// Holds the default datapath width and buffer depth, the encoding of the
// writeback source select, and the register-index width.
package reg_wb_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int DEPTH_DEF = 2;
  localparam int RD_W      = 5;

  // Writeback source select encoding.
  typedef enum logic [1:0] {
    WBS_ALU = 2'b00,
    WBS_MEM = 2'b01,
    WBS_PC4 = 2'b10,
    WBS_IMM = 2'b11
  } wb_sel_e;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small circular write buffer for pending register-file writes.
// Ports:
//   CLK, RESET     clock, asynchronous active-high reset (clears pointers/count)
//   push_i         enqueue push_data_i at the tail (caller guarantees not full)
//   pop_i          drop the head entry (caller guarantees not empty)
//   push_data_i    entry to store ({rd, data})
//   count_o        current occupancy, 0..DEPTH
//   ent_o          all slots presented in age order, ent_o[0] = head (oldest)
//   ent_vld_o      per age-ordered slot, 1 when that slot holds a live entry
module wb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               push_data_i,
  output logic [CW-1:0]              count_o,
  output logic [DEPTH-1:0][W-1:0]    ent_o,
  output logic [DEPTH-1:0]           ent_vld_o
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop_i)  head_d = ptr_inc(head_q);
    if (push_i) tail_d = ptr_inc(tail_q);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state: pointers and occupancy
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; liveness is tracked solely by the count.
  always_ff @(posedge CLK) begin
    if (push_i) mem[tail_q] <= push_data_i;
  end

  // Rotate storage into age order so the bypass logic can scan oldest->youngest.
  for (genvar k = 0; k < DEPTH; k++) begin : g_ent
    logic [PW:0] idx;
    assign idx          = {1'b0, head_q} + (PW+1)'(k);
    assign ent_o[k]     = mem[(idx >= (PW+1)'(DEPTH)) ? PW'(idx - (PW+1)'(DEPTH))
                                                      : idx[PW-1:0]];
    assign ent_vld_o[k] = CW'(k) < count_q;
  end

  assign count_o = count_q;

endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: buffers writeback results and drains them into the
// register-file write port, with bypass of pending values to readers.
// Ports:
//   CLK, RESET                         clock, asynchronous active-high reset
//   WB_VALID / WB_READY                upstream handshake (READY = not full)
//   WB_SEL                             source select (ALU, load, PC+4, imm)
//   WB_ALU, WB_MEM, WB_PC4, WB_IMM     candidate results
//   WB_RD, WB_REGWRITE                 destination and write enable
//   RF_HOLD                            freezes the register-file write port
//   RF_IN, RF_INADDRESS, RF_WRITEENABLE registered register-file write port
//   BYP_RS1/2, BYP_HIT1/2, BYP_DATA1/2 bypass lookup of pending writes
//   PENDING                            buffer occupancy (excludes strobed write)
module reg_writeback
  import reg_wb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            WB_VALID,
  output logic            WB_READY,
  input  logic [1:0]      WB_SEL,
  input  logic [XLEN-1:0] WB_ALU,
  input  logic [XLEN-1:0] WB_MEM,
  input  logic [XLEN-1:0] WB_PC4,
  input  logic [XLEN-1:0] WB_IMM,
  input  logic [4:0]      WB_RD,
  input  logic            WB_REGWRITE,
  input  logic            RF_HOLD,
  output logic [XLEN-1:0] RF_IN,
  output logic [5:0]      RF_INADDRESS,
  output logic            RF_WRITEENABLE,
  input  logic [4:0]      BYP_RS1,
  input  logic [4:0]      BYP_RS2,
  output logic            BYP_HIT1,
  output logic            BYP_HIT2,
  output logic [XLEN-1:0] BYP_DATA1,
  output logic [XLEN-1:0] BYP_DATA2,
  output logic [1:0]      PENDING
);

  localparam int EW = RD_W + XLEN;
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]              count;
  logic [DEPTH-1:0][EW-1:0]   ent;
  logic [DEPTH-1:0]           ent_vld;
  logic                       ready, push, pop;
  logic [XLEN-1:0]            sel_data;

  logic [XLEN-1:0] rf_in_q,   rf_in_d;
  logic [RD_W-1:0] rf_addr_q, rf_addr_d;
  logic            rf_we_q,   rf_we_d;

  function automatic logic [XLEN-1:0] wb_mux(input logic [1:0] sel);
    case (sel)
      WBS_ALU: return WB_ALU;
      WBS_MEM: return WB_MEM;
      WBS_PC4: return WB_PC4;
      default: return WB_IMM;
    endcase
  endfunction

  // Scan oldest->youngest so the youngest matching entry wins; the strobed
  // write is the lowest-priority source. x0 never hits.
  function automatic logic [XLEN:0] byp_lookup(input logic [4:0] rs);
    logic            hit;
    logic [XLEN-1:0] data;
    hit  = 1'b0;
    data = '0;
    if (rf_we_q && (rf_addr_q == rs)) begin
      hit  = 1'b1;
      data = rf_in_q;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (ent_vld[k] && (ent[k][EW-1:XLEN] == rs)) begin
        hit  = 1'b1;
        data = ent[k][XLEN-1:0];
      end
    end
    if (rs == '0) begin
      hit  = 1'b0;
      data = '0;
    end
    return {hit, data};
  endfunction

  // No pass-through when full: a pop on the same edge does not free a slot.
  assign ready    = count < CW'(DEPTH);
  assign sel_data = wb_mux(WB_SEL);
  // Results for x0 or non-writing instructions are consumed but dropped.
  assign push     = WB_VALID && ready && WB_REGWRITE && (WB_RD != '0);
  assign pop      = (count != '0) && !RF_HOLD;

  wb_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .CLK         (CLK),
    .RESET       (RESET),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i ({WB_RD, sel_data}),
    .count_o     (count),
    .ent_o       (ent),
    .ent_vld_o   (ent_vld)
  );

  always_comb begin
    rf_in_d   = rf_in_q;
    rf_addr_d = rf_addr_q;
    rf_we_d   = 1'b0;
    if (pop) begin
      rf_in_d   = ent[0][XLEN-1:0];
      rf_addr_d = ent[0][EW-1:XLEN];
      rf_we_d   = 1'b1;
    end
  end

  // Register-file write port stage
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rf_in_q   <= '0;
      rf_addr_q <= '0;
      rf_we_q   <= 1'b0;
    end else begin
      rf_in_q   <= rf_in_d;
      rf_addr_q <= rf_addr_d;
      rf_we_q   <= rf_we_d;
    end
  end

  assign WB_READY       = ready;
  assign RF_IN          = rf_in_q;
  assign RF_INADDRESS   = {1'b0, rf_addr_q};
  assign RF_WRITEENABLE = rf_we_q;
  assign PENDING        = 2'(count);
  assign {BYP_HIT1, BYP_DATA1} = byp_lookup(BYP_RS1);
  assign {BYP_HIT2, BYP_DATA2} = byp_lookup(BYP_RS2);

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter DEPTH, default 2, write-buffer entries.
REQ-003 SHALL have port CLK  in  1  clock; all state updates on posedge.
REQ-004 SHALL have port RESET  in  1  reset: asynchronous, active-high.
REQ-005 SHALL have port WB_VALID  in  1  upstream result valid.
REQ-006 SHALL have port WB_READY  out  1  buffer can accept.
REQ-007 SHALL have port WB_SEL  in  2  source select: 00 ALU, 01 load data, 10 PC+4, 11 immediate.
REQ-008 SHALL have ports WB_ALU, WB_MEM, WB_PC4, WB_IMM  in  XLEN  candidate results.
REQ-009 SHALL have port WB_RD  in  5  destination register.
REQ-010 SHALL have port WB_REGWRITE  in  1  instruction writes rd.
REQ-011 SHALL have port RF_HOLD  in  1  register-file write port frozen.
REQ-012 SHALL have port RF_IN  out  XLEN  register-file write data.
REQ-013 SHALL have port RF_INADDRESS  out  6  register-file write address; bit 5 always 0.
REQ-014 SHALL have port RF_WRITEENABLE  out  1  register-file write strobe.
REQ-015 SHALL have ports BYP_RS1, BYP_RS2  in  5  reader source addresses.
REQ-016 SHALL have ports BYP_HIT1, BYP_HIT2  out  1  pending write matches rsN.
REQ-017 SHALL have ports BYP_DATA1, BYP_DATA2  out  XLEN  newest pending value for rsN.
REQ-018 SHALL have port PENDING  out  2  buffer occupancy, 0..DEPTH.

Function
REQ-019 SHALL accept a result on a posedge where WB_VALID=1 and WB_READY=1.
REQ-020 SHALL drive WB_READY combinationally as (occupancy < DEPTH); no same-edge pop/push pass-through when full.
REQ-021 SHALL select data per WB_SEL at the accept edge and store {rd, data}.
REQ-022 SHALL consume without enqueuing when WB_REGWRITE=0 or WB_RD=0 (x0 never written).
REQ-023 SHALL, on each posedge with occupancy>0 and RF_HOLD=0, pop the head into registered outputs RF_IN/RF_INADDRESS with RF_WRITEENABLE=1 for exactly one cycle.
REQ-024 SHALL drive RF_WRITEENABLE=0 in every cycle after an edge that pops nothing; RF_IN/RF_INADDRESS hold last value.
REQ-025 SHALL give latency: accept at edge N -> RF_WRITEENABLE high from edge N+1 when buffer was empty and RF_HOLD=0.
REQ-026 SHALL preserve program order; push and pop on the same edge with occupancy 1 keeps occupancy 1.
REQ-027 SHALL, while RF_HOLD=1, neither pop nor strobe; accepts continue until full.
REQ-028 SHALL assert BYP_HITn combinationally when BYP_RSn!=0 and matches a buffer entry or the write currently strobed.
REQ-029 SHALL prioritise BYP_DATAn: youngest buffer entry, then older entry, then strobed write; 0 when no hit.
REQ-030 SHALL report PENDING as current buffer occupancy, excluding the strobed write.

Reset
REQ-031 SHALL, on RESET=1, immediately clear buffer, PENDING=0, RF_WRITEENABLE=0, RF_IN=0, RF_INADDRESS=0, BYP_HITn=0.
REQ-032 SHALL discard pending entries on reset mid-operation; no write is issued for them.
REQ-033 SHALL ignore WB_VALID while RESET=1; WB_READY=1 from first edge after release.

Structure
REQ-034 SHALL place XLEN, DEPTH defaults, WB_SEL encodings (WB_ALU=00, WB_MEM=01, WB_PC4=10, WB_IMM=11) in shared package reg_wb_pkg.
REQ-035 SHALL implement the buffer as sub-module wb_fifo (DEPTH entries, head/tail pointers, count, entry read-out for bypass).

Verification
REQ-036 SHALL cover: accept WB_SEL=00, WB_ALU=0x0000_1234, rd=5 at edge N -> edge N+1 RF_WRITEENABLE=1, RF_INADDRESS=5, RF_IN=0x1234, one cycle.
REQ-037 SHALL cover: WB_RD=0, WB_REGWRITE=1, WB_VALID=1 -> consumed, PENDING=0, no strobe.
REQ-038 SHALL cover: RF_HOLD=1, push rd=3 val 0xA then rd=3 val 0xB -> PENDING=2, WB_READY=0, BYP_RS1=3 gives HIT1=1, DATA1=0xB; release -> writes 0xA then 0xB on consecutive cycles.
REQ-039 SHALL cover: WB_SEL=10, WB_PC4=0x104, rd=1 -> RF_IN=0x104, RF_INADDRESS=1.
REQ-040 SHALL cover: two entries pending under RF_HOLD, RESET pulse -> PENDING=0, no RF_WRITEENABLE after release.
